hilo_muldiv_seq: RTL

HILO_MULDIV_SEQ -- requirements
Module: hilo_muldiv_seq

---
 rtl/hilo_muldiv_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_seq.sv
// hilo_muldiv_seq: sequential 32-step multiplier/divider owning the HI/LO register pair.
// Ports: clk, reset (async, active-low); start/op/srca/srcb launch MULT, MULTU, DIV, DIVU;
//   mt_hi/mt_lo/mt_data write HI/LO directly while idle; rd_req flags a pending mfhi/mflo;
//   busy/done/stall report status; hi/lo expose the registers.
// Divide support is compiled in only when HILO_DIV_EN is defined.
module hilo_muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             mt_hi,
   input  logic             mt_lo,
   input  logic [WIDTH-1:0] mt_data,
   input  logic             rd_req,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t             state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;
   logic               accept, sa_in, sb_in;
   logic [WIDTH:0]     add_s;
   logic [2*WIDTH-1:0] mul_step, prod;
`ifdef HILO_DIV_EN
   logic               div_q, div_d, sa_q, sa_d, ge;
   logic [WIDTH-1:0]   diff, quo, rem;
   logic [2*WIDTH-1:0] div_step;
`endif
   assign sa_in = !op[0] && srca[WIDTH-1];
   assign sb_in = !op[0] && srcb[WIDTH-1];
`ifdef HILO_DIV_EN
   assign accept = (state_q == IDLE) && start;
`else
   assign accept = (state_q == IDLE) && start && !op[1];
`endif
   // acc holds {partial product, remaining multiplier} and shifts right one bit per step
   assign add_s    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
   assign mul_step = acc_q[0] ? {add_s, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
   assign prod     = neg_q ? -acc_q : acc_q;
`ifdef HILO_DIV_EN
   // acc holds {partial remainder, dividend bits / quotient bits} and shifts left one bit per step;
   // the trial remainder needs WIDTH+1 bits, but a successful subtract always fits in WIDTH
   assign ge       = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, b_q};
   assign diff     = acc_q[2*WIDTH-2:WIDTH-1] - b_q;
   assign div_step = ge ? {diff, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-2:0], 1'b0};
   // divide by zero leaves |srca| as remainder, so sign correction restores srca in HI
   assign quo      = (b_q == '0) ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
   assign rem      = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      acc_d   = acc_q;
      b_d     = b_q;
      hi_d    = (state_q == IDLE && mt_hi) ? mt_data : hi_q;
      lo_d    = (state_q == IDLE && mt_lo) ? mt_data : lo_q;
      done_d  = 1'b0;
`ifdef HILO_DIV_EN
      div_d   = div_q;
      sa_d    = sa_q;
`endif
      case (state_q)
         IDLE: if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            neg_d   = sa_in ^ sb_in;
            acc_d   = {{WIDTH{1'b0}}, sa_in ? -srca : srca};
            b_d     = sb_in ? -srcb : srcb;
`ifdef HILO_DIV_EN
            div_d   = op[1];
            sa_d    = sa_in;
`endif
         end
         RUN: begin
`ifdef HILO_DIV_EN
            acc_d   = div_q ? div_step : mul_step;
`else
            acc_d   = mul_step;
`endif
            cnt_d   = cnt_q + 5'd1;
            state_d = (cnt_q == 5'(WIDTH-1)) ? FIN : RUN;
         end
         FIN: begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef HILO_DIV_EN
            {hi_d, lo_d} = div_q ? {rem, quo} : prod;
`else
            {hi_d, lo_d} = prod;
`endif
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
`ifdef HILO_DIV_EN
         div_q   <= 1'b0;
         sa_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
`ifdef HILO_DIV_EN
         div_q   <= div_d;
         sa_q    <= sa_d;
`endif
      end
   end
   assign busy  = state_q != IDLE;
   assign done  = done_q;
   assign stall = busy && (rd_req || mt_hi || mt_lo);
   assign hi    = hi_q;
   assign lo    = lo_q;
endmodule
